// File: rtl/prog_addr_decoder.sv
// rtl/prog_addr_decoder.sv - programmable registered address decoder
// Run-time lookup table with a one-entry output register and saturating miss counter.
module prog_addr_decoder #(
  parameter int                ADDR_W       = 3,
  parameter int                OUT_W        = 8,
  parameter logic [OUT_W-1:0]  DEFAULT_CODE = '0,
  parameter int                MISS_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [OUT_W-1:0]  cfg_code,
  input  logic              cfg_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_decode,
  output logic              out_hit,
  output logic [MISS_W-1:0] miss_count,
  input  logic              miss_clr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][OUT_W-1:0] code_q, code_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUT_W-1:0]            out_decode_q, out_decode_d;
  logic                        out_hit_q, out_hit_d;
  logic [MISS_W-1:0]           miss_q, miss_d;

  logic             accept;
  logic             lookup_hit;
  logic [OUT_W-1:0] lookup_code;

  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  // Lookup reads the registered table, so a same-cycle write is seen only by later lookups.
  assign lookup_hit  = valid_q[in_addr];
  assign lookup_code = lookup_hit ? code_q[in_addr] : DEFAULT_CODE;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    if (cfg_we) begin
      code_d[cfg_addr]  = cfg_code;
      valid_d[cfg_addr] = cfg_en;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q && !out_ready;
    out_decode_d = out_decode_q;
    out_hit_d    = out_hit_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_decode_d = lookup_code;
      out_hit_d    = lookup_hit;
    end
  end

  always_comb begin
    miss_d = miss_q;
    if (miss_clr) begin
      miss_d = '0;
    end else if (accept && !lookup_hit && (miss_q != {MISS_W{1'b1}})) begin
      miss_d = miss_q + MISS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q       <= '0;
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      out_decode_q <= '0;
      out_hit_q    <= 1'b0;
      miss_q       <= '0;
    end else begin
      code_q       <= code_d;
      valid_q      <= valid_d;
      out_valid_q  <= out_valid_d;
      out_decode_q <= out_decode_d;
      out_hit_q    <= out_hit_d;
      miss_q       <= miss_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_decode = out_decode_q;
  assign out_hit    = out_hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_prog_addr_decoder.sv
// tb/tb_prog_addr_decoder.sv - self-checking bench for prog_addr_decoder
// Table-driven lookups with a result scoreboard plus hand-written stall, saturation and reset sequences.
module tb_prog_addr_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_code;
  logic       cfg_en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_decode;
  logic       out_hit;
  logic [7:0] miss_count;
  logic       miss_clr;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [7:0] s_out_decode;
  logic       s_out_hit;
  logic [1:0] s_miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] code;
    logic       hit;
  } res_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] code;
    logic       hit;
  } vec_t;

  res_t exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  prog_addr_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_code(cfg_code), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_decode(out_decode),
    .out_hit(out_hit), .miss_count(miss_count), .miss_clr(miss_clr)
  );

  prog_addr_decoder #(.MISS_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_code(cfg_code), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_addr(in_addr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_decode(s_out_decode),
    .out_hit(s_out_hit), .miss_count(s_miss_count), .miss_clr(miss_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard drain: one result leaves the output register on each transfer edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_decode), 32'hFFFF_FFFF);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("sb_decode", 32'(out_decode), 32'(r.code));
        chk("sb_hit", 32'(out_hit), 32'(r.hit));
      end
    end
  end

  task automatic send(input logic [2:0] a, input logic [7:0] c, input logic h);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back('{code: c, hit: h});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) begin
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_decode", 32'(out_decode), 32'(c));
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] c, input logic en);
    cfg_we = 1'b1; cfg_addr = a; cfg_code = c; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3'd0, 8'h00, 1'b0};
    tbl[1] = '{3'd1, 8'h0B, 1'b1};
    tbl[2] = '{3'd2, 8'h2C, 1'b1};
    tbl[3] = '{3'd3, 8'h00, 1'b0};
    tbl[4] = '{3'd4, 8'h00, 1'b0};
    tbl[5] = '{3'd5, 8'h58, 1'b1};
    tbl[6] = '{3'd6, 8'h58, 1'b1};
    tbl[7] = '{3'd7, 8'h2A, 1'b1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_code = '0; cfg_en = 1'b0;
    in_valid = 1'b0; in_addr = '0; out_ready = 1'b1; miss_clr = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_decode", 32'(out_decode), 32'd0);
    chk("rst_out_hit", 32'(out_hit), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Empty table: every address misses.
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 8'h00, 1'b0);
      chk("empty_in_ready", 32'(in_ready), 32'd1);
    end
    chk("empty_miss", 32'(miss_count), 32'd8);

    cfg_write(3'd1, 8'h0B, 1'b1);
    cfg_write(3'd7, 8'h2A, 1'b1);
    cfg_write(3'd2, 8'h2C, 1'b1);
    cfg_write(3'd5, 8'h58, 1'b1);
    cfg_write(3'd6, 8'h58, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].addr, tbl[i].code, tbl[i].hit);
    end
    chk("prog_miss", 32'(miss_count), 32'd11);

    // Write and lookup of the same index in one cycle.
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_code = 8'h77; cfg_en = 1'b1;
    send(3'd3, 8'h00, 1'b0);
    cfg_we = 1'b0;
    send(3'd3, 8'h77, 1'b1);
    chk("rbw_miss", 32'(miss_count), 32'd12);

    // Drain then stall.
    idle();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_decode", 32'(out_decode), 32'h77);
    out_ready = 1'b0;
    send(3'd1, 8'h0B, 1'b1);
    fork
      send(3'd2, 8'h2C, 1'b1);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_decode", 32'(out_decode), 32'h0B);
          chk("stall_hit", 32'(out_hit), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    send(3'd3, 8'h77, 1'b1);
    send(3'd4, 8'h00, 1'b0);
    send(3'd5, 8'h58, 1'b1);
    idle();
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("stall_miss", 32'(miss_count), 32'd13);

    // Saturation on the MISS_W=2 instance.
    miss_clr = 1'b1;
    idle();
    miss_clr = 1'b0;
    chk("clr_miss", 32'(miss_count), 32'd0);
    chk("clr_miss_s", 32'(s_miss_count), 32'd0);
    for (int i = 0; i < 6; i++) send(3'd4, 8'h00, 1'b0);
    chk("sat_miss_s", 32'(s_miss_count), 32'd3);
    chk("sat_miss", 32'(miss_count), 32'd6);
    miss_clr = 1'b1;
    send(3'd0, 8'h00, 1'b0);
    miss_clr = 1'b0;
    chk("clr_prio_s", 32'(s_miss_count), 32'd0);
    chk("clr_prio", 32'(miss_count), 32'd0);
    send(3'd4, 8'h00, 1'b0);
    chk("after_clr_s", 32'(s_miss_count), 32'd1);
    chk("after_clr", 32'(miss_count), 32'd1);

    // Reset while a result is stalled in the output register.
    idle();
    out_ready = 1'b0;
    send(3'd5, 8'h58, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_decode", 32'(out_decode), 32'd0);
    chk("arst_hit", 32'(out_hit), 32'd0);
    chk("arst_miss", 32'(miss_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle();
    chk("arst_no_pulse", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    send(3'd1, 8'h00, 1'b0);
    send(3'd7, 8'h2A & 8'h00, 1'b0);
    send(3'd5, 8'h00, 1'b0);
    idle();
    chk("arst_miss_after", 32'(miss_count), 32'd3);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_addr_decoder.md
Name: prog_addr_decoder

Overview:
- Programmable, registered successor to the fixed 3-to-8 case-table address decoder.
- Holds a run-time-writable lookup table of 2**ADDR_W entries. Each entry is an OUT_W-bit code plus a valid bit.
- Lookups arrive over a valid/ready stream and return the code, a hit flag and a saturating miss count.
- Sits between bus address generation and per-target select logic, replacing hard-wired decode tables.

Parameters:
- ADDR_W, 3, lookup/config address width; table depth = 2**ADDR_W.
- OUT_W, 8, width of each decode code.
- DEFAULT_CODE, 0, code returned on a miss (entry valid bit clear); OUT_W bits.
- MISS_W, 8, width of saturating miss counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  entry index to write.
- cfg_code  in  OUT_W  code to store.
- cfg_en  in  1  valid bit to store (0 = entry disabled).
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup request accepted when in_valid & in_ready.
- in_addr  in  ADDR_W  address to decode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_decode  out  OUT_W  decoded code (stored code on hit, DEFAULT_CODE on miss).
- out_hit  out  1  1 = entry valid at lookup time.
- miss_count  out  MISS_W  saturating count of accepted lookups that missed.
- miss_clr  in  1  synchronous clear of miss_count.

Behaviour:
- Reset (rst_n low, async, effective immediately):
  - all table valid bits = 0 and all codes = 0;
  - out_valid = 0, out_decode = 0, out_hit = 0, miss_count = 0.
  - in_ready = 1 from the first edge after release.
- Table write: on a clk edge with cfg_we = 1, entry[cfg_addr] <= {cfg_en, cfg_code}. Always accepted; no handshake.
- Output stage: single register. in_ready = !out_valid | out_ready, purely combinational; no combinational path from in_* to out_*.
- Accept (in_valid & in_ready):
  - next edge sets out_valid = 1;
  - out_hit = entry[in_addr].valid;
  - out_decode = entry code if hit, else DEFAULT_CODE.
  - Latency is exactly 1 cycle. Full throughput of 1 lookup/cycle while out_ready = 1.
- Stall (out_valid & !out_ready): out_valid, out_decode and out_hit hold stable. in_ready = 0, so no request is lost.
- Drain (out_valid & out_ready & !accept): next edge clears out_valid. out_decode and out_hit hold their last values.
- Write/lookup to the same index in the same cycle: the lookup returns the pre-write contents (read-before-write). The new value is visible to lookups accepted on later cycles.
- A result already held in the output register is not changed by later table writes.
- miss_count:
  - increments by 1 on each accepted lookup that misses;
  - saturates at 2**MISS_W-1 with no wrap;
  - miss_clr takes priority, giving 0 on the next edge even if a miss is accepted in the same cycle.
- Reset asserted mid-transfer: the pending result is discarded, the table is cleared, and no out_valid pulse follows release.
- in_addr is ADDR_W wide, so every index is in range; there is no out-of-range case.

Test Plan:
- Reset, then look up all 8 addresses with out_ready = 1 and no writes:
  - every result has out_hit = 0 and out_decode = 0x00;
  - miss_count = 8;
  - in_ready stays 1 throughout.
- Program 1->0x0B, 7->0x2A, 2->0x2C, 5->0x58, 6->0x58 (cfg_en = 1), then stream addresses 0..7 back-to-back:
  - results are 0x00, 0x0B, 0x2C, 0x00, 0x00, 0x58, 0x58, 0x2A;
  - hits are 0,1,1,0,0,1,1,1;
  - each result appears 1 cycle after its accept;
  - miss_count rises by 3.
- Same cycle: cfg_we writes entry 3 = 0x77 and a lookup of address 3 is accepted:
  - that result is a miss with 0x00;
  - a lookup of 3 on the next cycle returns 0x77 with hit = 1.
- Hold out_ready = 0 for 5 cycles with in_valid = 1:
  - out_decode and out_hit stay frozen and in_ready = 0;
  - on release, the queued lookups complete in order with none dropped or duplicated.
- MISS_W = 2: run 6 misses, then 1 miss concurrent with miss_clr:
  - count saturates at 3, then reads 0;
  - the next miss gives 1.
- Assert rst_n low while out_valid = 1 and stalled:
  - outputs clear asynchronously and previously programmed entries read as misses after release.
